demux_1xn_deser: RTL and testbench



---
 rtl/demux_1xn_deser.sv | 107 ++++++++++
 tb/tb_demux_1xn_deser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1xn_deser.sv
// demux_1xn_deser
//   Registered, back-pressured 1-to-N channel splitter with per-channel
//   deserialisation. Each accepted serial bit goes to the channel picked by
//   S. Each channel shifts its bits in MSB-first. When W bits have arrived,
//   the channel presents the word with a valid/ack handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   I          serial data bit
//   S          channel select for the current bit
//   in_valid   I/S qualify this cycle
//   in_ready   stage can take the bit addressed by S this cycle
//   out_valid  per-channel word-ready flags (bit k = channel k)
//   out_data   packed words, channel k at [k*W +: W]
//   out_ack    per-channel consume strobe
//   sel_err    one-cycle pulse after a bit is dropped for an illegal select
module demux_1xn_deser #(
  parameter int N_CH  = 2,
  parameter int W     = 8,
  parameter int SEL_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I,
  input  logic [SEL_W-1:0]  S,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N_CH-1:0]   out_valid,
  output logic [N_CH*W-1:0] out_data,
  input  logic [N_CH-1:0]   out_ack,
  output logic              sel_err
);

  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;

  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] full;
  logic            sel_legal;
  logic            accept;

  // One-hot decode of S. An out-of-range select matches no channel. This
  // is how illegal selects are detected without indexing past N_CH.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N_CH; k++) begin
      hit[k] = (S == SEL_W'(k));
    end
  end

  assign sel_legal = |hit;

  // in_ready depends only on registered full flags and on S. An ack in the
  // same cycle does not free the slot until the next cycle.
  assign in_ready  = !sel_legal || !(|(hit & full));
  assign accept    = in_valid && in_ready;
  assign out_valid = full;

  // A dropped illegal bit is reported one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= accept && !sel_legal;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] cnt;
    logic             full_r;
    logic [W-1:0]     word_r;
    logic [W-1:0]     shifted;

    assign shifted = {shreg[W-2:0], I};
    assign full[k] = full_r;
    assign out_data[k*W +: W] = word_r;

    // Per-channel packer.
    // An accept can only target this channel while it is not full, so the
    // ack-clear and the word-complete set never collide on full_r.
    // word_r keeps the last word after it has been consumed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shreg  <= '0;
        cnt    <= '0;
        full_r <= 1'b0;
        word_r <= '0;
      end else begin
        if (full_r && out_ack[k]) begin
          full_r <= 1'b0;
        end
        if (accept && hit[k]) begin
          shreg <= shifted;
          if (cnt == CNT_W'(W - 1)) begin
            cnt    <= '0;
            full_r <= 1'b1;
            word_r <= shifted;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_1xn_deser.sv
// tb_demux_1xn_deser
//   Bench for demux_1xn_deser with N_CH=3, W=4, SEL_W=2, so that S=3 is an
//   illegal select. A behavioural model tracks the per-channel count, shift
//   and full state. It also pushes every completed word into a per-channel
//   queue. Queued words are compared while the DUT presents them and popped
//   on ack.
module tb_demux_1xn_deser;

  localparam int N_CH  = 3;
  localparam int W     = 4;
  localparam int SEL_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              I;
  logic [SEL_W-1:0]  S;
  logic              in_valid;
  logic              in_ready;
  logic [N_CH-1:0]   out_valid;
  logic [N_CH*W-1:0] out_data;
  logic [N_CH-1:0]   out_ack;
  logic              sel_err;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [W-1:0] mSh  [4];
  int           mCnt [4];
  logic [3:0]   mFull;
  logic         expSelErr;
  logic [W-1:0] expQ [N_CH][$];

  demux_1xn_deser #(.N_CH(N_CH), .W(W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .I         (I),
    .S         (S),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ack   (out_ack),
    .sel_err   (sel_err)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns the model to its reset state and drops any pending words.
  task automatic resetModel();
    for (int k = 0; k < 4; k++) begin
      mSh[k]  = '0;
      mCnt[k] = 0;
    end
    for (int k = 0; k < N_CH; k++) begin
      expQ[k].delete();
    end
    mFull     = '0;
    expSelErr = 1'b0;
  endtask

  // Drives one cycle of inputs shortly after a rising edge. Outputs are
  // checked on the falling edge, the model is advanced, and the task
  // returns 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic b,
                               input logic [2:0] ack);
    logic         expReady;
    logic [W-1:0] word;
    in_valid = v;
    S        = s;
    I        = b;
    out_ack  = ack;
    @(negedge clk);
    expReady = (s < 2'd3) ? !mFull[s] : 1'b1;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
    checkOutput("out_valid", {29'd0, out_valid}, {29'd0, mFull[2:0]});
    checkOutput("sel_err", {31'd0, sel_err}, {31'd0, expSelErr});
    for (int k = 0; k < N_CH; k++) begin
      if (mFull[k]) begin
        if (expQ[k].size() == 0) begin
          checkOutput("queue_empty", 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("data_ch%0d", k), {28'd0, out_data[k*W +: W]},
                      {28'd0, expQ[k][0]});
        end
      end
    end
    expSelErr = v && (s == 2'd3);
    for (int k = 0; k < N_CH; k++) begin
      if (ack[k] && mFull[k]) begin
        mFull[k] = 1'b0;
        void'(expQ[k].pop_front());
      end
    end
    if (v && expReady && s < 2'd3) begin
      word   = {mSh[s][W-2:0], b};
      mSh[s] = word;
      if (mCnt[s] == W - 1) begin
        mCnt[s]  = 0;
        mFull[s] = 1'b1;
        expQ[s].push_back(word);
      end else begin
        mCnt[s]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Sends a W-bit word to one channel, MSB first, with no acks.
  task automatic sendBits(input logic [1:0] sel, input logic [W-1:0] bits);
    for (int i = W - 1; i >= 0; i--) begin
      applyStimulus(1'b1, sel, bits[i], 3'b000);
    end
  endtask

  initial begin
    logic [31:0] r;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    S        = '0;
    I        = 1'b0;
    out_ack  = '0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {29'd0, out_valid}, 32'd0);
    checkOutput("rst_data", {20'd0, out_data}, 32'd0);
    checkOutput("rst_sel_err", {31'd0, sel_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word on channel 0.
    sendBits(2'd0, 4'b1011);
    checkOutput("t1_valid", {29'd0, out_valid}, 32'b001);
    checkOutput("t1_data_lo", {28'd0, out_data[3:0]}, 32'b1011);
    checkOutput("t1_data_hi", {28'd0, out_data[7:4]}, 32'd0);

    // Back-pressure while channel 0 stays full, then release it.
    repeat (3) applyStimulus(1'b1, 2'd0, 1'b1, 3'b000);
    checkOutput("t2_backpressure", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b001);
    checkOutput("t2_ack_clear", {31'd0, out_valid[0]}, 32'd0);
    sendBits(2'd0, 4'b1010);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b001);

    // Interleaved channels 0 and 1.
    for (int i = 3; i >= 0; i--) begin
      r = 32'b1100;
      applyStimulus(1'b1, 2'd0, r[i], 3'b000);
      r = 32'b0101;
      applyStimulus(1'b1, 2'd1, r[i], 3'b000);
    end
    checkOutput("t3_valid", {29'd0, out_valid}, 32'b011);
    checkOutput("t3_data", {24'd0, out_data[7:0]}, 32'b0101_1100);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b011);

    // Illegal select in the middle of a channel-2 word.
    applyStimulus(1'b1, 2'd2, 1'b1, 3'b000);
    applyStimulus(1'b1, 2'd2, 1'b1, 3'b000);
    applyStimulus(1'b1, 2'd3, 1'b1, 3'b000);
    checkOutput("t4_pulse", {31'd0, sel_err}, 32'd1);
    applyStimulus(1'b1, 2'd2, 1'b1, 3'b000);
    checkOutput("t4_pulse_end", {31'd0, sel_err}, 32'd0);
    applyStimulus(1'b1, 2'd2, 1'b0, 3'b000);
    checkOutput("t4_data", {28'd0, out_data[11:8]}, 32'b1110);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b100);

    // Ack and a new bit for the same full channel in one cycle.
    sendBits(2'd1, 4'b1001);
    applyStimulus(1'b1, 2'd1, 1'b1, 3'b010);
    sendBits(2'd1, 4'b1011);
    checkOutput("t5_data", {28'd0, out_data[7:4]}, 32'b1011);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b010);

    // Asynchronous reset mid-word with a word pending on channel 1.
    sendBits(2'd1, 4'b0011);
    applyStimulus(1'b1, 2'd0, 1'b1, 3'b000);
    applyStimulus(1'b1, 2'd0, 1'b1, 3'b000);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", {29'd0, out_valid}, 32'd0);
    checkOutput("t6_async_data", {20'd0, out_data}, 32'd0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sendBits(2'd0, 4'b0110);
    checkOutput("t6_fresh_data", {28'd0, out_data[3:0]}, 32'b0110);
    checkOutput("t6_other_clear", {24'd0, out_data[11:4]}, 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b001);

    // Random traffic across all selects, with random acks.
    repeat (80) begin
      r = $urandom;
      applyStimulus(r[0], r[2:1], r[3], r[6:4]);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
